// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - single-clock FIFO with programmable almost-full/almost-empty thresholds and sticky error
module fifo_umbral #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  fifo_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic rd_accept;
    logic wr_accept;
    logic overflow;
    logic underflow;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CNT_DEPTH);
    assign almost_full  = (count >= umbral_alto);
    assign almost_empty = (count <= umbral_bajo);

    // A full FIFO still takes a write when a pop frees the slot in the same edge.
    assign rd_accept = rd_enable && !fifo_empty;
    assign wr_accept = wr_enable && (!fifo_full || rd_accept);
    assign overflow  = wr_enable && fifo_full && !rd_accept;
    assign underflow = rd_enable && fifo_empty;

    // Storage has no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= mem[rd_ptr];
            end
            valid_out <= rd_accept;
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (overflow || underflow) begin
                fifo_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - randomized and directed self-checking bench for fifo_umbral
module tb_fifo_umbral;

    logic       clk;
    logic       reset;
    logic       wr_enable;
    logic [5:0] data_in;
    logic       rd_enable;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       fifo_error;

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of stored words plus the registered outputs.
    logic [5:0] q[$];
    logic [5:0] m_dout;
    logic       m_valid;
    logic       m_err;

    fifo_umbral #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_enable    (wr_enable),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] expv();
        return {m_dout, m_valid, q.size() == 0, q.size() == 8,
                q.size() >= int'(umbral_alto), q.size() <= int'(umbral_bajo), m_err};
    endfunction

    function automatic logic [11:0] dutv();
        return {data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty, fifo_error};
    endfunction

    task automatic cycle(input logic w, input logic [5:0] d, input logic r);
        bit full_now, empty_now, rd_acc, wr_acc;
        wr_enable = w;
        data_in   = d;
        rd_enable = r;
        @(posedge clk);
        full_now  = (q.size() == 8);
        empty_now = (q.size() == 0);
        if (!reset) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
        end else begin
            rd_acc = r && !empty_now;
            wr_acc = w && (!full_now || rd_acc);
            m_valid = rd_acc;
            if (rd_acc) m_dout = q.pop_front();
            if (wr_acc) q.push_back(d);
            if ((w && !wr_acc) || (r && !rd_acc)) m_err = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle(1'b0, 6'h00, 1'b0);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycle(1'b1, 6'h11, 1'b1);
        cycle(1'b1, 6'h12, 1'b0);
        reset = 1'b1;
        umbral_bajo = 4'd0;
        #1;
        total++;
        if ({fifo_empty, fifo_full, almost_empty, fifo_error, valid_out, data_out} !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'h00}) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b",
                     {fifo_empty, fifo_full, almost_empty, fifo_error, valid_out, data_out}, 11'b10100_000000);
        end
        cycle(1'b0, 6'h00, 1'b0);
        total++;
        if (dutv() !== expv()) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", dutv(), expv());
        end
    endtask

    task automatic test_fill_drain();
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 6'(i), 1'b0);
            total++;
            if ({almost_full, fifo_full, fifo_error} !== {i >= 6, i == 8, 1'b0}) begin
                bad++;
                $display("FAIL fill_flags[%0d] got=%b want=%b", i,
                         {almost_full, fifo_full, fifo_error}, {i >= 6, i == 8, 1'b0});
            end
        end
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
            total++;
            if ({data_out, valid_out, almost_empty, fifo_empty, fifo_error} !==
                {6'(i), 1'b1, (8 - i) <= 2, i == 8, 1'b0}) begin
                bad++;
                $display("FAIL drain[%0d] got=%h want=%h", i,
                         {data_out, valid_out, almost_empty, fifo_empty, fifo_error},
                         {6'(i), 1'b1, (8 - i) <= 2, i == 8, 1'b0});
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) cycle(1'b1, 6'(8 + i), 1'b0);
        cycle(1'b1, 6'h3F, 1'b0);
        total++;
        if ({fifo_error, fifo_full, valid_out} !== 3'b110) begin
            bad++;
            $display("FAIL overflow_flags got=%b want=110", {fifo_error, fifo_full, valid_out});
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
            total++;
            if ({data_out, valid_out} !== {6'(8 + i), 1'b1}) begin
                bad++;
                $display("FAIL overflow_read[%0d] got=%h want=%h", i, {data_out, valid_out}, {6'(8 + i), 1'b1});
            end
        end
        cycle(1'b0, 6'h00, 1'b0);
        total++;
        if ({fifo_empty, fifo_error} !== 2'b11) begin
            bad++;
            $display("FAIL overflow_sticky got=%b want=11", {fifo_empty, fifo_error});
        end
    endtask

    task automatic test_underflow_simul();
        do_reset();
        cycle(1'b1, 6'h15, 1'b1);
        total++;
        if ({fifo_empty, valid_out, fifo_error} !== 3'b001) begin
            bad++;
            $display("FAIL empty_simul got=%b want=001", {fifo_empty, valid_out, fifo_error});
        end
        cycle(1'b0, 6'h00, 1'b1);
        total++;
        if ({data_out, valid_out, fifo_empty} !== {6'h15, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL empty_simul_read got=%h want=%h", {data_out, valid_out, fifo_empty}, {6'h15, 2'b11});
        end
    endtask

    task automatic test_full_simul_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 6'(16 + i), 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 6'h00, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 6'(32 + i), 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 6'h2A, 1'b1);
            total++;
            if ({data_out, valid_out, fifo_full, fifo_error} !== {6'(32 + k), 1'b1, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL full_simul[%0d] got=%h want=%h", k,
                         {data_out, valid_out, fifo_full, fifo_error}, {6'(32 + k), 3'b110});
            end
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 6'h00, 1'b1);
            total++;
            if (data_out !== ((i < 5) ? 6'(35 + i) : 6'h2A)) begin
                bad++;
                $display("FAIL wrap_order[%0d] got=%h want=%h", i, data_out, (i < 5) ? 6'(35 + i) : 6'h2A);
            end
        end
    endtask

    task automatic test_thresholds();
        umbral_alto = 4'd0;
        #1;
        total++;
        if ({fifo_empty, almost_full} !== 2'b11) begin
            bad++;
            $display("FAIL alto_zero got=%b want=11", {fifo_empty, almost_full});
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 6'($urandom), 1'b0);
        for (int b = 8; b < 16; b += 7) begin
            umbral_bajo = 4'(b);
            #1;
            total++;
            if ({fifo_full, almost_empty} !== 2'b11) begin
                bad++;
                $display("FAIL bajo_edge[%0d] got=%b want=11", b, {fifo_full, almost_empty});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i), 1'b0);
        cycle(1'b0, 6'h00, 1'b1);
        cycle(1'b1, 6'h07, 1'b0);
        reset = 1'b0;
        cycle(1'b1, 6'h33, 1'b0);
        reset = 1'b1;
        total++;
        if ({fifo_empty, fifo_error, valid_out} !== 3'b100) begin
            bad++;
            $display("FAIL reset_mid got=%b want=100", {fifo_empty, fifo_error, valid_out});
        end
        cycle(1'b0, 6'h00, 1'b1);
        total++;
        if ({fifo_empty, fifo_error, valid_out} !== 3'b110) begin
            bad++;
            $display("FAIL reset_mid_underflow got=%b want=110", {fifo_empty, fifo_error, valid_out});
        end
    endtask

    task automatic test_random();
        bit bias;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) bias = ~bias;
            if ($urandom_range(0, 19) == 0) begin
                umbral_alto = 4'($urandom);
                umbral_bajo = 4'($urandom);
            end
            reset = ($urandom_range(0, 99) != 0);
            cycle($urandom_range(0, 99) < (bias ? 75 : 25), 6'($urandom), $urandom_range(0, 99) < (bias ? 25 : 75));
            reset = 1'b1;
            total++;
            if (dutv() !== expv()) begin
                bad++;
                $display("FAIL random[%0d] got=%h want=%h", n, dutv(), expv());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        data_in = '0;
        umbral_alto = 4'd6;
        umbral_bajo = 4'd2;
        m_dout = '0;
        m_valid = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_simul();
        test_full_simul_wrap();
        test_thresholds();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
Synchronous single-clock FIFO with programmable almost-full and almost-empty thresholds and a sticky error flag. It sits directly upstream of the flow-control FSM. One instance per buffer (main FIFO, virtual channels, destinations). Its fifo_empty and fifo_error outputs are concatenated into the FSM's FIFO_EMPTY[4:0] and FIFO_ERROR[4:0] buses, and its umbral inputs are driven from the thresholds latched by the FSM.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8 entries)

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
wr_enable  input  1  write request
data_in  input  DATA_WIDTH  write data
rd_enable  input  1  read request
umbral_alto  input  ADDR_WIDTH+1  almost-full threshold (entries)
umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold (entries)
data_out  output  DATA_WIDTH  registered read data
valid_out  output  1  data_out holds a word popped on the previous edge
fifo_empty  output  1  count == 0
fifo_full  output  1  count == DEPTH
almost_full  output  1  count >= umbral_alto
almost_empty  output  1  count <= umbral_bajo
fifo_error  output  1  sticky overflow/underflow indicator

Behaviour:
- Reset is sampled at posedge clk while reset == 0:
  - wr_ptr, rd_ptr, count <= 0; data_out <= 0; valid_out <= 0; fifo_error <= 0.
  - Storage array is not cleared.
  - Because count = 0, fifo_empty = 1, fifo_full = 0, and almost_empty = 1 for any umbral_bajo.
  - Reset overrides any wr/rd request in the same cycle. Reset mid-operation discards all contents.
- State:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap modulo DEPTH (7 -> 0).
  - count is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Write accept: wr_enable && (!fifo_full || rd_accept). mem[wr_ptr] <= data_in; wr_ptr++.
- Read accept (rd_accept): rd_enable && !fifo_empty. data_out <= mem[rd_ptr]; rd_ptr++; valid_out <= 1.
  - In any cycle without rd_accept: valid_out <= 0 and data_out holds its last value.
- Read latency: 1 cycle. The word appears on data_out at the same edge that accepts the read, so it is visible during the following cycle.
- Count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both are accepted or neither is.
- Simultaneous wr+rd:
  - Full: both accepted, count stays DEPTH, no error.
  - Empty: write accepted, read rejected (data is not bypassed), underflow error set.
- Overflow: wr_enable while full without rd_accept. Write dropped, pointers unchanged, fifo_error <= 1.
- Underflow: rd_enable while empty. No pop, valid_out <= 0, fifo_error <= 1.
- fifo_error stays 1 until reset. It is not cleared by subsequent legal traffic.
- Status flags are combinational from registered count and the current umbral inputs. They reflect an accepted operation one cycle after the accepting edge.
- Threshold edge values:
  - umbral_alto = 0 makes almost_full constantly 1.
  - umbral_bajo >= DEPTH makes almost_empty constantly 1.
  - Thresholds may change at any time; the flags track them combinationally.
- No internal FSM beyond the pointer/count registers. Block behaviour is independent of the FSM's init.

Test Plan:
1. Reset then idle: reset=0 for 2 edges, then 1 -> fifo_empty=1, fifo_full=0, almost_empty=1, fifo_error=0, valid_out=0, data_out=0.
2. Fill and drain:
   - Stimulus: umbral_alto=6, umbral_bajo=2; write 8 words 0x01..0x08 on consecutive edges; then read 8.
   - almost_full rises after the 6th write; fifo_full rises after the 8th.
   - data_out sequence is 0x01..0x08, each with valid_out=1 one cycle after its read.
   - almost_empty rises when count reaches 2; fifo_empty rises after the 8th read; fifo_error stays 0.
3. Overflow: with the FIFO full, write 0x3F -> fifo_error=1, count stays 8; subsequent reads return the original 8 words without 0x3F; fifo_error is still 1 afterwards.
4. Underflow/empty simultaneous: on empty, rd_enable=1 together with wr_enable=1 and data 0x15 -> count=1, valid_out=0, fifo_error=1; next-cycle read returns 0x15.
5. Full simultaneous and wrap:
   - Stimulus: with 8 entries stored after pointer wrap (write 5, read 5, write 8), assert wr+rd with 0x2A for 3 cycles.
   - count stays 8, fifo_error=0, outputs continue in FIFO order.
   - 0x2A is read after the 8 older words.
6. Reset mid-operation: with count=4 and wr_enable=1 in the same cycle, reset=0 -> count=0, fifo_empty=1, fifo_error cleared, valid_out=0; a read on the next cycle flags underflow.
